// File: rtl/cand_pkg.sv
// Shared widths, scan FSM states and {id, score} packing helpers for the
// cluster-head candidate bank.
package cand_pkg;

  localparam int DEF_ID_WIDTH    = 8;
  localparam int DEF_SCORE_WIDTH = 8;
  localparam int DEF_DEPTH       = 16;

  // Helpers work on wide containers so one definition serves every width.
  localparam int MAX_FIELD = 32;
  localparam int MAX_WORD  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic logic [MAX_WORD-1:0] packCand(
    input logic [MAX_FIELD-1:0] id,
    input logic [MAX_FIELD-1:0] score,
    input int                   scoreWidth
  );
    logic [MAX_WORD-1:0] idPart;
    idPart = {{(MAX_WORD-MAX_FIELD){1'b0}}, id} << scoreWidth;
    return idPart | {{(MAX_WORD-MAX_FIELD){1'b0}}, score};
  endfunction

  function automatic logic [MAX_FIELD-1:0] candId(
    input logic [MAX_WORD-1:0] word,
    input int                  scoreWidth
  );
    return MAX_FIELD'(word >> scoreWidth);
  endfunction

  function automatic logic [MAX_FIELD-1:0] candScore(
    input logic [MAX_WORD-1:0] word,
    input int                  scoreWidth
  );
    return MAX_FIELD'(word & ((MAX_WORD'(1) << scoreWidth) - MAX_WORD'(1)));
  endfunction

endpackage

// File: rtl/cand_storage.sv
// Candidate register array: one write port, two zero-latency read ports
// (external index and scan pointer). Contents are deliberately not reset.
module cand_storage
  import cand_pkg::*;
#(
  parameter  int WORD  = DEF_ID_WIDTH + DEF_SCORE_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_wrEn,
  input  logic [AW-1:0]   i_wrAddr,
  input  logic [WORD-1:0] i_wrData,
  input  logic [AW-1:0]   i_rdAddrA,
  output logic [WORD-1:0] o_rdDataA,
  input  logic [AW-1:0]   i_rdAddrB,
  output logic [WORD-1:0] o_rdDataB
);

  logic [WORD-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdDataA = r_mem[i_rdAddrA];
  assign o_rdDataB = r_mem[i_rdAddrB];

endmodule

// File: rtl/candidate_bank.sv
// Append-only (id, score) store with masked indexed read, occupancy flags,
// synchronous clear and a one-entry-per-cycle max-score scan engine.
module candidate_bank
  import cand_pkg::*;
#(
  parameter  int ID_WIDTH    = DEF_ID_WIDTH,
  parameter  int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter  int DEPTH       = DEF_DEPTH,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int WORD        = ID_WIDTH + SCORE_WIDTH
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [ID_WIDTH-1:0]    wr_id,
  input  logic [SCORE_WIDTH-1:0] wr_score,
  output logic                   wr_ovf,
  input  logic [AW-1:0]          rd_addr,
  output logic [ID_WIDTH-1:0]    rd_id,
  output logic [SCORE_WIDTH-1:0] rd_score,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  input  logic                   scan_start,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic [ID_WIDTH-1:0]    best_id,
  output logic [SCORE_WIDTH-1:0] best_score,
  output logic                   best_valid
);

  logic [CW-1:0]          r_count;
  logic                   r_wrOvf;
  scan_state_e            r_state;
  scan_state_e            w_stateNext;
  logic [AW-1:0]          r_ptr;
  logic [AW-1:0]          w_ptrNext;
  logic [CW-1:0]          r_limit;
  logic [CW-1:0]          w_limitNext;
  logic [ID_WIDTH-1:0]    r_bestId;
  logic [ID_WIDTH-1:0]    w_bestIdNext;
  logic [SCORE_WIDTH-1:0] r_bestScore;
  logic [SCORE_WIDTH-1:0] w_bestScoreNext;
  logic                   r_bestValid;
  logic                   w_bestValidNext;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_wrAccept;
  logic [WORD-1:0]        w_wrWord;
  logic [WORD-1:0]        w_rdWord;
  logic [WORD-1:0]        w_scanWord;
  logic [AW-1:0]          w_scanAddr;
  logic                   w_rdHit;
  logic [ID_WIDTH-1:0]    w_scanId;
  logic [SCORE_WIDTH-1:0] w_scanScore;
  logic                   w_lastEntry;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_wrAccept = wr_en && !w_full && !clr;
  assign w_wrWord   = WORD'(packCand(MAX_FIELD'(wr_id), MAX_FIELD'(wr_score), SCORE_WIDTH));

  // Port B sits at entry 0 outside SCAN so IDLE can seed best_id on start.
  assign w_scanAddr = (r_state == ST_SCAN) ? r_ptr : '0;

  cand_storage #(
    .WORD  (WORD),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk       (clk),
    .i_wrEn    (w_wrAccept),
    .i_wrAddr  (r_count[AW-1:0]),
    .i_wrData  (w_wrWord),
    .i_rdAddrA (rd_addr),
    .o_rdDataA (w_rdWord),
    .i_rdAddrB (w_scanAddr),
    .o_rdDataB (w_scanWord)
  );

  assign w_rdHit     = (CW'(rd_addr) < r_count);
  assign rd_id       = w_rdHit ? ID_WIDTH'(candId(MAX_WORD'(w_rdWord), SCORE_WIDTH)) : '0;
  assign rd_score    = w_rdHit ? SCORE_WIDTH'(candScore(MAX_WORD'(w_rdWord), SCORE_WIDTH)) : '0;
  assign w_scanId    = ID_WIDTH'(candId(MAX_WORD'(w_scanWord), SCORE_WIDTH));
  assign w_scanScore = SCORE_WIDTH'(candScore(MAX_WORD'(w_scanWord), SCORE_WIDTH));
  assign w_lastEntry = (CW'(r_ptr) == (r_limit - CW'(1)));

  // Occupancy; clr wins over a same-cycle append and suppresses the overflow pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
      r_wrOvf <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_wrOvf <= 1'b0;
    end else begin
      r_wrOvf <= wr_en && w_full;
      if (w_wrAccept) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_limit     <= '0;
      r_bestId    <= '0;
      r_bestScore <= '0;
      r_bestValid <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_ptr       <= w_ptrNext;
      r_limit     <= w_limitNext;
      r_bestId    <= w_bestIdNext;
      r_bestScore <= w_bestScoreNext;
      r_bestValid <= w_bestValidNext;
    end
  end

  // Strict greater-than keeps the lowest index on ties; the limit is latched
  // at start so entries appended mid-scan are never examined.
  always_comb begin
    w_stateNext     = r_state;
    w_ptrNext       = r_ptr;
    w_limitNext     = r_limit;
    w_bestIdNext    = r_bestId;
    w_bestScoreNext = r_bestScore;
    w_bestValidNext = r_bestValid;
    if (clr) begin
      w_stateNext     = ST_IDLE;
      w_ptrNext       = '0;
      w_bestIdNext    = '0;
      w_bestScoreNext = '0;
      w_bestValidNext = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (scan_start) begin
            w_bestValidNext = 1'b0;
            w_bestScoreNext = '0;
            w_ptrNext       = '0;
            if (w_empty) begin
              w_bestIdNext = '0;
              w_stateNext  = ST_DONE;
            end else begin
              w_limitNext  = r_count;
              w_bestIdNext = w_scanId;
              w_stateNext  = ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (w_scanScore > r_bestScore) begin
            w_bestIdNext    = w_scanId;
            w_bestScoreNext = w_scanScore;
          end
          if (w_lastEntry) begin
            w_bestValidNext = 1'b1;
            w_ptrNext       = '0;
            w_stateNext     = ST_DONE;
          end else begin
            w_ptrNext = r_ptr + AW'(1);
          end
        end
        ST_DONE: begin
          w_stateNext = ST_IDLE;
        end
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

  assign wr_ovf     = r_wrOvf;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign scan_busy  = (r_state == ST_SCAN);
  assign scan_done  = (r_state == ST_DONE);
  assign best_id    = r_bestId;
  assign best_score = r_bestScore;
  assign best_valid = r_bestValid;

endmodule
